bram_activity_sched: RTL and testbench
======================================

BRAM_ACTIVITY_SCHED -- requirements
Module: bram_activity_sched

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: BRAM address width.
REQ-002 SHALL have parameter DATA_W, default 32: BRAM write-data width.
REQ-003 SHALL have parameter SETTLE_CYC, default 16: clocks with clk_en high before traffic starts.
REQ-004 SHALL have port clk100m, input, 1: sole clock, free-running and ungated.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: single-cycle run request, sampled only in IDLE.
REQ-007 SHALL have port run_cycles, input, 32: ACTIVE length per burst in clocks, latched at start.
REQ-008 SHALL have port gate_cycles, input, 16: GATED length per burst in clocks, latched at start.
REQ-009 SHALL have port bursts, input, 8: number of SETTLE/ACTIVE/GATED bursts, latched at start.
REQ-010 SHALL have port wr_ratio, input, 2: write mix, 0=reads only, 1=1 write in 4, 2=1 write in 2, 3=writes only.
REQ-011 SHALL have port clk_en, output, 1: drives the CE of the user-clock BUFGCE.
REQ-012 SHALL have ports bram_en (output, 1), bram_we (output, 1), bram_addr (output, ADDR_W) and bram_wdata (output, DATA_W): registered BRAM stimulus broadcast to all DUTs.
REQ-013 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and burst_idx (output, 8, index of the current burst).

Function
REQ-014 SHALL implement the states IDLE, SETTLE, ACTIVE, DRAIN, GATED and FIN.
REQ-015 In IDLE, start=1 with bursts!=0 and run_cycles!=0 SHALL latch the inputs and go to SETTLE on the next clock.
REQ-016 In IDLE, start=1 with bursts=0 or run_cycles=0 SHALL go directly to FIN, with no BRAM activity.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC clocks with clk_en=1 and bram_en=0, then go to ACTIVE.
REQ-018 ACTIVE SHALL last exactly run_cycles clocks with clk_en=1 and bram_en=1.
REQ-019 In ACTIVE, bram_addr SHALL increment by 1 each clock and wrap from 2^ADDR_W-1 to 0.
REQ-020 In ACTIVE, bram_we SHALL follow wr_ratio using the 2 LSBs of a cycle counter: ratio 1 writes when bits==3; ratio 2 writes when bit0==1.
REQ-021 DRAIN SHALL last exactly 2 clocks with clk_en=1 and bram_en=0, so that in-flight BRAM reads retire before gating.
REQ-022 GATED SHALL hold clk_en=0 for gate_cycles clocks.
REQ-023 If gate_cycles=0, GATED SHALL be skipped entirely.
REQ-024 After GATED, the block SHALL increment burst_idx and return to SETTLE if burst_idx+1 < bursts; otherwise it SHALL go to FIN.
REQ-025 FIN SHALL pulse done for exactly 1 clock, restore clk_en=1, and return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start asserted while busy SHALL be ignored.
REQ-028 bram_addr SHALL restart at 0 at the start of every burst.
REQ-029 All outputs SHALL be registered.
REQ-030 clk_en SHALL change only on the FSM state register edge, with no combinational path to the BUFGCE.
REQ-031 In IDLE, clk_en SHALL be 1 and bram_en, bram_we and bram_addr SHALL be 0.

Reset
REQ-032 rst=1 SHALL force on the next edge: state=IDLE, clk_en=1, bram_en=0, bram_we=0, bram_addr=0, burst_idx=0, busy=0 and done=0.
REQ-033 bram_wdata SHALL reset to 0 when SCHED_LFSR_DATA_EN is undefined, and to the nonzero seed when it is defined.
REQ-034 rst asserted mid-run, including in GATED, SHALL abort the run without a done pulse and SHALL re-enable clk_en on that same edge.

Configuration
REQ-035 When SCHED_LFSR_DATA_EN is defined, bram_wdata SHALL advance a maximal-length Galois LFSR (seed 'h1, never all-zero) on every write.
REQ-036 When SCHED_LFSR_DATA_EN is undefined, bram_wdata SHALL invert all bits on every write (0 <-> all-ones), giving a 100% deterministic toggle rate.

Structure
REQ-037 Package sched_pkg SHALL hold the state enum, the wr_ratio encodings, DRAIN_CYC=2 and the LFSR tap constants for DATA_W=32.
REQ-038 The block SHALL have one sub-module, sched_lfsr (DATA_W, seed, advance enable), instantiated only under SCHED_LFSR_DATA_EN.
REQ-039 A single down-counter SHALL be shared by SETTLE, ACTIVE, DRAIN and GATED, with the burst counter kept separate.

Verification
REQ-040 Bench SHALL cover: SETTLE_CYC=16, run_cycles=8, gate_cycles=4, bursts=1, wr_ratio=3 -> clk_en low exactly 4 clocks; 8 writes to addresses 0..7; done 1 clock after GATED; busy exactly 16+8+2+4+1 clocks.
REQ-041 Bench SHALL cover: bursts=3, gate_cycles=0 -> clk_en never low; burst_idx steps 0,1,2; addresses restart at 0 each burst; one done.
REQ-042 Bench SHALL cover: ADDR_W=4, run_cycles=20, wr_ratio=1 -> address sequence 0..15,0..3 and bram_we high on cycle counts 3,7,11,15,19.
REQ-043 Bench SHALL cover: rst pulsed on clock 2 of GATED -> clk_en=1 the following cycle, no done pulse, then a new start runs normally.
REQ-044 Bench SHALL cover: start with run_cycles=0 -> done the next clock, bram_en never high; start pulsed while busy -> no effect.
REQ-045 Bench SHALL cover, with SCHED_LFSR_DATA_EN undefined: 4 writes -> bram_wdata sequence FFFFFFFF, 0, FFFFFFFF, 0.
REQ-046 Bench SHALL cover, with SCHED_LFSR_DATA_EN defined: bram_wdata never 0 and first value matches the reference LFSR model.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared types and constants for the BRAM activity scheduler: FSM states,
// write-mix encodings, drain length and the 32-bit Galois LFSR taps.
package sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_GATED  = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WR_NONE    = 2'd0,
    WR_QUARTER = 2'd1,
    WR_HALF    = 2'd2,
    WR_ALL     = 2'd3
  } wr_ratio_e;

  localparam int DRAIN_CYC = 2;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED    = 32'h0000_0001;

  // Decide whether the ACTIVE cycle with the given counter LSBs is a write.
  function automatic logic write_slot(input wr_ratio_e ratio, input logic [1:0] slot);
    logic wr;
    case (ratio)
      WR_QUARTER: wr = (slot == 2'd3);
      WR_HALF:    wr = slot[0];
      WR_ALL:     wr = 1'b1;
      default:    wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/bram_activity_sched_if.sv
// BRAM stimulus bus broadcast from the scheduler (master) to every BRAM
// under test (slave).
interface bram_activity_sched_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;

  modport master (output bram_en, output bram_we, output bram_addr, output bram_wdata);
  modport slave  (input  bram_en, input  bram_we, input  bram_addr, input  bram_wdata);
endinterface

// File: rtl/sched_lfsr.sv
// Galois LFSR write-data generator; advances one step per asserted adv and
// never reaches all-zero from a nonzero seed.
module sched_lfsr
  import sched_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  SEED   = DATA_W'(LFSR_SEED),
  parameter logic [DATA_W-1:0]  TAPS   = DATA_W'(LFSR_TAPS_32)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= SEED;
    else if (adv) q <= (q >> 1) ^ (q[0] ? TAPS : '0);
  end

endmodule

// File: rtl/bram_activity_sched.sv
// Burst scheduler for BRAM power tests: SETTLE/ACTIVE/DRAIN/GATED per burst,
// gating the user clock via clk_en. Define SCHED_LFSR_DATA_EN for LFSR write data.
//
// state  | meaning
// IDLE   | waiting for start, clk_en=1, bus quiet
// SETTLE | clock running, no BRAM traffic for SETTLE_CYC clocks
// ACTIVE | run_cycles clocks of BRAM traffic, address ramps from 0
// DRAIN  | DRAIN_CYC quiet clocks so in-flight reads retire
// GATED  | clk_en=0 for gate_cycles clocks (skipped when zero)
// FIN    | one-clock done pulse, then back to IDLE
module bram_activity_sched
  import sched_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int SETTLE_CYC = 16
) (
  input  logic        clk100m,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] run_cycles,
  input  logic [15:0] gate_cycles,
  input  logic [7:0]  bursts,
  input  logic [1:0]  wr_ratio,
  bram_activity_sched_if.master bram,
  output logic        clk_en,
  output logic        busy,
  output logic        done,
  output logic [7:0]  burst_idx
);

  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] DRAIN_LOAD  = 32'(DRAIN_CYC - 1);

  state_e            state;
  logic [31:0]       cnt;
  logic [31:0]       run_q;
  logic [15:0]       gate_q;
  logic [7:0]        bursts_q;
  wr_ratio_e         ratio_q;
  logic [1:0]        cyc;
  logic              en_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              wr_adv;
  logic              last_burst;

  // wr_adv is high exactly when the next ACTIVE cycle carries a write
  always_comb begin
    wr_adv = 1'b0;
    if (state == ST_SETTLE && cnt == '0)
      wr_adv = write_slot(ratio_q, 2'd0);
    else if (state == ST_ACTIVE && cnt != '0)
      wr_adv = write_slot(ratio_q, cyc);
    last_burst = ({1'b0, burst_idx} + 9'd1) >= {1'b0, bursts_q};
  end

`ifdef SCHED_LFSR_DATA_EN
  sched_lfsr #(
    .DATA_W (DATA_W),
    .SEED   (DATA_W'(LFSR_SEED)),
    .TAPS   (DATA_W'(LFSR_TAPS_32))
  ) u_lfsr (
    .clk (clk100m),
    .rst (rst),
    .adv (wr_adv),
    .q   (wdata_r)
  );
`else
  always_ff @(posedge clk100m) begin
    if (rst)         wdata_r <= '0;
    else if (wr_adv) wdata_r <= ~wdata_r;
  end
`endif

  always_ff @(posedge clk100m) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      run_q     <= '0;
      gate_q    <= '0;
      bursts_q  <= '0;
      ratio_q   <= WR_NONE;
      cyc       <= '0;
      clk_en    <= 1'b1;
      en_r      <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      burst_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          busy      <= 1'b1;
          run_q     <= run_cycles;
          gate_q    <= gate_cycles;
          bursts_q  <= bursts;
          ratio_q   <= wr_ratio_e'(wr_ratio);
          burst_idx <= '0;
          if (bursts != '0 && run_cycles != '0) begin
            state <= ST_SETTLE;
            cnt   <= SETTLE_LOAD;
          end else begin
            state <= ST_FIN;
            done  <= 1'b1;
          end
        end
        ST_SETTLE: if (cnt == '0) begin
          state  <= ST_ACTIVE;
          cnt    <= run_q - 32'd1;
          en_r   <= 1'b1;
          we_r   <= wr_adv;
          addr_r <= '0;
          cyc    <= 2'd1;
        end else cnt <= cnt - 32'd1;
        ST_ACTIVE: if (cnt == '0) begin
          state  <= ST_DRAIN;
          cnt    <= DRAIN_LOAD;
          en_r   <= 1'b0;
          we_r   <= 1'b0;
          addr_r <= '0;
        end else begin
          cnt    <= cnt - 32'd1;
          addr_r <= addr_r + 1'b1;
          we_r   <= wr_adv;
          cyc    <= cyc + 2'd1;
        end
        ST_DRAIN: if (cnt == '0) begin
          if (gate_q != '0) begin
            state  <= ST_GATED;
            cnt    <= {16'd0, gate_q - 16'd1};
            clk_en <= 1'b0;
          end else if (last_burst) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            state     <= ST_SETTLE;
            cnt       <= SETTLE_LOAD;
            burst_idx <= burst_idx + 8'd1;
          end
        end else cnt <= cnt - 32'd1;
        ST_GATED: if (cnt == '0) begin
          clk_en <= 1'b1;
          if (last_burst) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            state     <= ST_SETTLE;
            cnt       <= SETTLE_LOAD;
            burst_idx <= burst_idx + 8'd1;
          end
        end else cnt <= cnt - 32'd1;
        ST_FIN: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bram.bram_en    = en_r;
  assign bram.bram_we    = we_r;
  assign bram.bram_addr  = addr_r;
  assign bram.bram_wdata = wdata_r;

endmodule

// File: tb/tb_bram_activity_sched.sv
// Directed self-checking bench for bram_activity_sched: a default instance and
// a 4-bit-address instance share the clock; outputs are sampled on negedges.
module tb_bram_activity_sched;

  logic        clk = 1'b0;
  logic        rst, start0, start1, sel;
  logic [31:0] run_cycles;
  logic [15:0] gate_cycles;
  logic [7:0]  bursts;
  logic [1:0]  wr_ratio;
  logic        ce0, busy0, done0, ce1, busy1, done1;
  logic [7:0]  bidx0, bidx1;

  always #5 clk = ~clk;

  bram_activity_sched_if #(.ADDR_W(10), .DATA_W(32)) b0 ();
  bram_activity_sched_if #(.ADDR_W(4),  .DATA_W(32)) b1 ();

  bram_activity_sched #(.ADDR_W(10), .DATA_W(32), .SETTLE_CYC(16)) u0 (
    .clk100m(clk), .rst(rst), .start(start0), .run_cycles(run_cycles),
    .gate_cycles(gate_cycles), .bursts(bursts), .wr_ratio(wr_ratio),
    .bram(b0), .clk_en(ce0), .busy(busy0), .done(done0), .burst_idx(bidx0));

  bram_activity_sched #(.ADDR_W(4), .DATA_W(32), .SETTLE_CYC(4)) u1 (
    .clk100m(clk), .rst(rst), .start(start1), .run_cycles(run_cycles),
    .gate_cycles(gate_cycles), .bursts(bursts), .wr_ratio(wr_ratio),
    .bram(b1), .clk_en(ce1), .busy(busy1), .done(done1), .burst_idx(bidx1));

  logic        s_busy, s_ce, s_done, s_en, s_we;
  logic [9:0]  s_addr;
  logic [31:0] s_wdata;
  logic [7:0]  s_bidx;

  always_comb begin
    s_busy  = sel ? busy1 : busy0;
    s_ce    = sel ? ce1 : ce0;
    s_done  = sel ? done1 : done0;
    s_en    = sel ? b1.bram_en : b0.bram_en;
    s_we    = sel ? b1.bram_we : b0.bram_we;
    s_addr  = sel ? {6'd0, b1.bram_addr} : b0.bram_addr;
    s_wdata = sel ? b1.bram_wdata : b0.bram_wdata;
    s_bidx  = sel ? bidx1 : bidx0;
  end

  int checks = 0;
  int errors = 0;
  int n_busy, n_low, n_en, n_done, done_at, last_low_at, timeout;
  logic [9:0]  addrs[$];
  logic        wes[$];
  logic [31:0] wdat[$];
  logic [7:0]  bstarts[$];
  logic [9:0]  bstart_addr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic which);
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Samples once per negedge until busy drops; optionally pokes start0 at one sample.
  task automatic collect(input int budget, input int poke_at);
    logic prev_en;
    n_busy = 0; n_low = 0; n_en = 0; n_done = 0;
    done_at = -1; last_low_at = -1; timeout = 1;
    addrs.delete(); wes.delete(); wdat.delete(); bstarts.delete(); bstart_addr.delete();
    prev_en = 1'b0;
    for (int i = 0; i < budget; i++) begin
      n_busy += int'(s_busy);
      n_en   += int'(s_en);
      if (!s_ce) begin n_low++; last_low_at = i; end
      if (s_done) begin n_done++; done_at = i; end
      if (s_en) begin
        addrs.push_back(s_addr);
        wes.push_back(s_we);
        if (s_we) wdat.push_back(s_wdata);
      end
      if (s_en && !prev_en) begin
        bstarts.push_back(s_bidx);
        bstart_addr.push_back(s_addr);
      end
      prev_en = s_en;
      if (!s_busy) begin timeout = 0; break; end
      start0 = (i == poke_at);
      @(negedge clk);
    end
    start0 = 1'b0;
  endtask

  initial begin
    logic        ok;
    int          cnt_w;
    logic [31:0] model;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
    run_cycles = '0; gate_cycles = '0; bursts = '0; wr_ratio = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_clk_en", ce0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_bram_en", b0.bram_en, 0);
    chk("rst_bram_we", b0.bram_we, 0);
    chk("rst_bram_addr", b0.bram_addr, 0);
    chk("rst_burst_idx", bidx0, 0);
`ifdef SCHED_LFSR_DATA_EN
    chk("rst_wdata", b0.bram_wdata, 32'h1);
`else
    chk("rst_wdata", b0.bram_wdata, 32'h0);
`endif
    rst = 1'b0;

    // single burst, all writes, gated 4
    run_cycles = 8; gate_cycles = 4; bursts = 1; wr_ratio = 3;
    pulse(1'b0);
    collect(200, -1);
    chk("t1_timeout", timeout, 0);
    chk("t1_busy_clocks", n_busy, 31);
    chk("t1_clk_en_low", n_low, 4);
    chk("t1_last_low_at", last_low_at, 29);
    chk("t1_done_count", n_done, 1);
    chk("t1_done_at", done_at, 30);
    chk("t1_en_clocks", n_en, 8);
    chk("t1_writes", wdat.size(), 8);
    ok = (addrs.size() == 8);
    foreach (addrs[i]) if (addrs[i] != 10'(i)) ok = 1'b0;
    chk("t1_addr_seq", ok, 1);
`ifdef SCHED_LFSR_DATA_EN
    model = 32'h1;
    model = (model >> 1) ^ (model[0] ? 32'h8020_0003 : 32'h0);
    chk("t1_lfsr_first", wdat[0], model);
    ok = 1'b1;
    foreach (wdat[i]) if (wdat[i] == 32'h0) ok = 1'b0;
    chk("t1_lfsr_nonzero", ok, 1);
`else
    chk("t1_wdata0", wdat[0], 32'hFFFF_FFFF);
    chk("t1_wdata1", wdat[1], 32'h0);
    chk("t1_wdata2", wdat[2], 32'hFFFF_FFFF);
    chk("t1_wdata3", wdat[3], 32'h0);
`endif

    // three bursts, no gating, reads only
    run_cycles = 8; gate_cycles = 0; bursts = 3; wr_ratio = 0;
    pulse(1'b0);
    collect(400, -1);
    chk("t2_timeout", timeout, 0);
    chk("t2_clk_en_low", n_low, 0);
    chk("t2_done_count", n_done, 1);
    chk("t2_busy_clocks", n_busy, 79);
    chk("t2_en_clocks", n_en, 24);
    chk("t2_writes", wdat.size(), 0);
    chk("t2_burst_count", bstarts.size(), 3);
    chk("t2_bidx0", bstarts[0], 0);
    chk("t2_bidx1", bstarts[1], 1);
    chk("t2_bidx2", bstarts[2], 2);
    ok = (addrs.size() == 24);
    foreach (addrs[i]) if (addrs[i] != 10'(i % 8)) ok = 1'b0;
    chk("t2_addr_restart", ok, 1);

    // 4-bit address wrap, 1 write in 4
    sel = 1'b1;
    run_cycles = 20; gate_cycles = 0; bursts = 1; wr_ratio = 1;
    pulse(1'b1);
    collect(200, -1);
    chk("t3_timeout", timeout, 0);
    chk("t3_busy_clocks", n_busy, 27);
    ok = (addrs.size() == 20);
    foreach (addrs[i]) if (addrs[i] != 10'(i % 16)) ok = 1'b0;
    chk("t3_addr_wrap", ok, 1);
    ok = (wes.size() == 20);
    foreach (wes[i]) if (wes[i] != ((i % 4) == 3)) ok = 1'b0;
    chk("t3_we_slots", ok, 1);
    chk("t3_writes", wdat.size(), 5);
    sel = 1'b0;

    // reset on the second GATED clock
    run_cycles = 8; gate_cycles = 4; bursts = 1; wr_ratio = 3;
    pulse(1'b0);
    cnt_w = 0;
    while (ce0 && cnt_w < 100) begin @(negedge clk); cnt_w++; end
    chk("t4_reach_gated", ce0, 0);
    @(negedge clk);
    chk("t4_gated_clock2", ce0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_clk_en_restored", ce0, 1);
    chk("t4_busy_cleared", busy0, 0);
    chk("t4_no_done", done0, 0);
    cnt_w = 0;
    repeat (8) begin @(negedge clk); cnt_w += int'(done0); end
    chk("t4_no_late_done", cnt_w, 0);
    pulse(1'b0);
    collect(200, -1);
    chk("t4_rerun_busy", n_busy, 31);
    chk("t4_rerun_done", n_done, 1);
    chk("t4_rerun_low", n_low, 4);

    // zero-length requests go straight to FIN
    run_cycles = 0; gate_cycles = 4; bursts = 1;
    pulse(1'b0);
    collect(20, -1);
    chk("t5_run0_done", n_done, 1);
    chk("t5_run0_done_at", done_at, 0);
    chk("t5_run0_en", n_en, 0);
    chk("t5_run0_busy", n_busy, 1);
    run_cycles = 8; bursts = 0;
    pulse(1'b0);
    collect(20, -1);
    chk("t5_burst0_done_at", done_at, 0);
    chk("t5_burst0_en", n_en, 0);

    // start while busy is ignored
    run_cycles = 8; gate_cycles = 0; bursts = 1; wr_ratio = 2;
    pulse(1'b0);
    collect(200, 5);
    chk("t6_busy_clocks", n_busy, 27);
    chk("t6_done_count", n_done, 1);
    chk("t6_en_clocks", n_en, 8);
    chk("t6_writes", wdat.size(), 4);
    repeat (4) @(negedge clk);
    chk("t6_stays_idle", busy0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
